// File: rtl/io_write_arbiter_if.sv
// Write-port bus between the writeback stage / I/O sources and the register-file arbiter.
// The ovf_cnt signal exists only when IO_OVERWRITE_COUNT_EN is defined.
interface io_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic                cpu_we;
  logic [ADDR_W-1:0]   cpu_waddr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic [2:0]          src_req;
  logic [3*DATA_W-1:0] src_data;
  logic [2:0]          src_busy;
  logic [2:0]          src_ack;
  logic                stall_req;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
`ifdef IO_OVERWRITE_COUNT_EN
  logic [3*CNT_W-1:0]  ovf_cnt;
`endif

  modport slave (
    input  cpu_we, cpu_waddr, cpu_wdata, src_req, src_data,
    output src_busy, src_ack, stall_req, rf_we, rf_waddr, rf_wdata
`ifdef IO_OVERWRITE_COUNT_EN
    , output ovf_cnt
`endif
  );

  modport master (
    output cpu_we, cpu_waddr, cpu_wdata, src_req, src_data,
    input  src_busy, src_ack, stall_req, rf_we, rf_waddr, rf_wdata
`ifdef IO_OVERWRITE_COUNT_EN
    , input ovf_cnt
`endif
  );
endinterface

// File: rtl/io_write_arbiter.sv
// Shares the regfile write port between CPU writeback and three latched I/O event sources (r20/r22/r24).
// Optional IO_OVERWRITE_COUNT_EN adds saturating per-source overwrite counters on ovf_cnt.
module io_src_slot #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              req,
  input  logic              gnt,
  input  logic [DATA_W-1:0] din,
  output logic              pend,
  output logic [DATA_W-1:0] hold
`ifdef IO_OVERWRITE_COUNT_EN
  , output logic [CNT_W-1:0] ovf
`endif
);
  // A new request in the grant cycle wins, leaving a second write queued.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pend <= 1'b0;
      hold <= '0;
    end else if (req) begin
      pend <= 1'b1;
      hold <= din;
    end else if (gnt) begin
      pend <= 1'b0;
    end
  end

`ifdef IO_OVERWRITE_COUNT_EN
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)                          ovf <= '0;
    else if (req && pend && !gnt && ovf != '1)  ovf <= ovf + 1'b1;
  end
`endif
endmodule

module io_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BTN_REG  = 20,
  parameter int SCR_REG  = 22,
  parameter int COL_REG  = 24,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input logic              clock,
  input logic              ctrl_reset_n,
  io_write_arbiter_if.slave bus
);
  localparam int WC_W = $clog2(MAX_WAIT + 1);

  logic [2:0]             pend, gnt;
  logic [2:0][DATA_W-1:0] hold;
  logic [1:0]             rr, sel;
  logic [WC_W-1:0]        wcnt;
  logic                   any, stall_now, io_gnt, cpu_take;
  logic [ADDR_W-1:0]      dst;
`ifdef IO_OVERWRITE_COUNT_EN
  logic [2:0][CNT_W-1:0]  ovf;
  assign bus.ovf_cnt = ovf;
`endif

  for (genvar i = 0; i < 3; i++) begin : g_slot
    io_src_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n),
      .req(bus.src_req[i]), .gnt(gnt[i]),
      .din(bus.src_data[i*DATA_W +: DATA_W]),
      .pend(pend[i]), .hold(hold[i])
`ifdef IO_OVERWRITE_COUNT_EN
      , .ovf(ovf[i])
`endif
    );
  end

  assign bus.src_busy = pend;
  assign any          = |pend;
  assign stall_now    = any && (wcnt == WC_W'(MAX_WAIT));
  assign io_gnt       = stall_now || (any && !bus.cpu_we);
  assign cpu_take     = bus.cpu_we && !stall_now;
  assign gnt          = io_gnt ? (3'b001 << sel) : 3'b000;

  // Round-robin pick: scan downward so the smallest offset from rr wins.
  always_comb begin
    int idx;
    sel = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= 3) idx = idx - 3;
      if (pend[idx]) sel = idx[1:0];
    end
  end

  always_comb begin
    case (sel)
      2'd0:    dst = ADDR_W'(BTN_REG);
      2'd1:    dst = ADDR_W'(SCR_REG);
      default: dst = ADDR_W'(COL_REG);
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rr   <= 2'd0;
      wcnt <= '0;
    end else begin
      if (io_gnt) rr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      wcnt <= (io_gnt || !any) ? '0 : wcnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.src_ack   <= 3'b000;
      bus.stall_req <= 1'b0;
    end else begin
      bus.rf_we     <= io_gnt || cpu_take;
      bus.src_ack   <= gnt;
      bus.stall_req <= stall_now;
      if (io_gnt) begin
        bus.rf_waddr <= dst;
        bus.rf_wdata <= hold[sel];
      end else if (cpu_take) begin
        bus.rf_waddr <= bus.cpu_waddr;
        bus.rf_wdata <= bus.cpu_wdata;
      end
    end
  end
endmodule
